stage_ff: RTL and testbench

STAGE_FF -- requirements
Module: stage_ff

---
 rtl/lc3b_types.sv | 19 +
 rtl/ff.sv | 26 ++
 rtl/stage_slot.sv | 30 +++
 rtl/stage_ff.sv | 132 +++++++++++++
 tb/tb_stage_ff.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: machine word and pipeline-stage occupancy states.
package lc3b_types;

  localparam int unsigned WORD_W = 16;

  typedef logic [WORD_W-1:0] lc3b_word;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } stage_state_t;

  // Encoding is chosen so the state value is the entry count.
  function automatic logic [1:0] state_occupancy(input stage_state_t s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/ff.sv
// Generic enabled register with synchronous reset and synchronous clear to RESET_VAL.
module ff #(
  parameter int unsigned       WIDTH     = 16,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      data_q <= RESET_VAL;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/stage_slot.sv
// One pipeline-stage entry: NFIELDS words with load and synchronous clear.
module stage_slot
  import lc3b_types::*;
#(
  parameter int unsigned NFIELDS    = 2,
  parameter lc3b_word    RESET_WORD = 16'h0000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     load_i,
  input  lc3b_word [NFIELDS-1:0]   d_i,
  output lc3b_word [NFIELDS-1:0]   q_o
);

  for (genvar f = 0; f < NFIELDS; f++) begin : g_field
    ff #(
      .WIDTH     (WORD_W),
      .RESET_VAL (RESET_WORD)
    ) u_ff (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clr_i),
      .en_i  (load_i),
      .d_i   (d_i[f]),
      .q_o   (q_o[f])
    );
  end

endmodule

// File: rtl/stage_ff.sv
// Valid/ready pipeline stage register with optional skid slot.
// Define STAGE_FF_SKID_EN for a registered in_ready backed by a second (skid) entry.
module stage_ff
  import lc3b_types::*;
#(
  parameter int unsigned NFIELDS    = 2,
  parameter lc3b_word    RESET_WORD = 16'h0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  lc3b_word [NFIELDS-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output lc3b_word [NFIELDS-1:0]  out_data,
  output logic [1:0]              occupancy
);

  stage_state_t           state_q, state_d;
  logic                   out_valid_q;
  logic [1:0]             occupancy_q;
  logic                   accept, consume;
  logic                   main_load;
  lc3b_word [NFIELDS-1:0] main_d;

`ifdef STAGE_FF_SKID_EN
  logic                   in_ready_q;
  logic                   skid_load, skid_clr;
  lc3b_word [NFIELDS-1:0] skid_q;

  assign in_ready = in_ready_q;
`else
  assign in_ready = !out_valid_q || out_ready;
`endif

  assign accept    = in_valid && in_ready;
  assign consume   = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign occupancy = occupancy_q;

  // Next state and slot controls; flush wins over accept/consume.
  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    main_d    = in_data;
`ifdef STAGE_FF_SKID_EN
    skid_load = 1'b0;
    skid_clr  = flush;
`endif
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = FULL;
          main_load = 1'b1;
        end
      end
      FULL: begin
        if (accept && consume) begin
          main_load = 1'b1;
        end else if (consume) begin
          state_d = EMPTY;
`ifdef STAGE_FF_SKID_EN
        end else if (accept) begin
          state_d   = SKID;
          skid_load = 1'b1;
`endif
        end
      end
`ifdef STAGE_FF_SKID_EN
      SKID: begin
        if (consume) begin
          state_d   = FULL;
          main_load = 1'b1;
          main_d    = skid_q;
          skid_clr  = 1'b1;
        end
      end
`endif
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      occupancy_q <= 2'd0;
`ifdef STAGE_FF_SKID_EN
      in_ready_q  <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d != EMPTY);
      occupancy_q <= state_occupancy(state_d);
`ifdef STAGE_FF_SKID_EN
      in_ready_q  <= (state_d != SKID);
`endif
    end
  end

  stage_slot #(
    .NFIELDS    (NFIELDS),
    .RESET_WORD (RESET_WORD)
  ) u_main (
    .clk_i  (clk),
    .rst_i  (reset),
    .clr_i  (flush),
    .load_i (main_load),
    .d_i    (main_d),
    .q_o    (out_data)
  );

`ifdef STAGE_FF_SKID_EN
  stage_slot #(
    .NFIELDS    (NFIELDS),
    .RESET_WORD (RESET_WORD)
  ) u_skid (
    .clk_i  (clk),
    .rst_i  (reset),
    .clr_i  (skid_clr),
    .load_i (skid_load),
    .d_i    (in_data),
    .q_o    (skid_q)
  );
`endif

endmodule

// File: tb/tb_stage_ff.sv
// Directed bench for stage_ff (NFIELDS=2 and NFIELDS=4 instances); follows STAGE_FF_SKID_EN.
module tb_stage_ff;
  import lc3b_types::*;

`ifdef STAGE_FF_SKID_EN
  localparam int unsigned CAP = 2;
`else
  localparam int unsigned CAP = 1;
`endif

  typedef lc3b_word [1:0] entry_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  entry_t       in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  entry_t       out_data;
  logic [1:0]   occupancy;

  logic                 in_valid4 = 1'b0;
  logic                 in_ready4;
  lc3b_word [3:0]       in_data4 = '0;
  logic                 out_valid4;
  logic                 out_ready4 = 1'b0;
  lc3b_word [3:0]       out_data4;
  logic [1:0]           occupancy4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stage_ff #(.NFIELDS(2), .RESET_WORD(16'h0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  stage_ff #(.NFIELDS(4), .RESET_WORD(16'h0000)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .in_data   (in_data4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out_data  (out_data4),
    .occupancy (occupancy4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    entry_t zero = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    checks++; if (out_data !== zero) begin errors++; $display("FAIL reset_data: got %h want %h", out_data, zero); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL reset_valid4: got %b want 0", out_valid4); end
  endtask

  task automatic test_basic();
    entry_t exp = {16'h3002, 16'h1261};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = exp;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== exp) begin errors++; $display("FAIL basic_data: got %h want %h", out_data, exp); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL basic_occ: got %0d want 1", occupancy); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain_valid: got %b want 0", out_valid); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL basic_drain_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_skid();
    lc3b_word a = 16'h1111;
    lc3b_word b = 16'h2222;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {a, a};
    tick();
    in_data = {b, b};
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (occupancy !== 2'(CAP)) begin errors++; $display("FAIL stall_occ: got %0d want %0d", occupancy, CAP); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
    checks++; if (out_data[0] !== a || out_data[1] !== a) begin errors++; $display("FAIL stall_data: got %h want %h%h", out_data, a, a); end
    out_ready = 1'b1;
    tick();
`ifdef STAGE_FF_SKID_EN
    checks++; if (out_data[0] !== b || out_data[1] !== b) begin errors++; $display("FAIL skid_second: got %h want %h%h", out_data, b, b); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL skid_second_occ: got %0d want 1", occupancy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_reopen: got %b want 1", in_ready); end
`else
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL noskid_drain_occ: got %0d want 0", occupancy); end
`endif
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL skid_drain_valid: got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    entry_t zero = '0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {16'h3333, 16'h3333};
    tick();
    in_data = {16'h4444, 16'h4444};
    tick();
    checks++; if (occupancy !== 2'(CAP)) begin errors++; $display("FAIL flush_pre_occ: got %0d want %0d", occupancy, CAP); end
    flush   = 1'b1;
    in_data = {16'h5555, 16'h5555};
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== zero) begin errors++; $display("FAIL flush_data: got %h want %h", out_data, zero); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_reset_stall();
    entry_t zero = '0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {16'h6666, 16'h6666};
    tick();
    in_data = {16'h7777, 16'h7777};
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    reset     = 1'b1;
    tick();
    reset     = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rst_stall_occ: got %0d want 0", occupancy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stall_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== zero) begin errors++; $display("FAIL rst_stall_data: got %h want %h", out_data, zero); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stall_ghost: got %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    entry_t exp_q[$];
    int sent = 0;
    int rcvd = 0;
    int cyc  = 0;
    while (rcvd < 100 && cyc < 3000) begin
      in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
      in_data   = {16'(16'hC000 + sent), 16'(sent * 7 + 1)};
      out_ready = ($urandom_range(0, 1) == 1);
      #1;
      checks++;
      if (occupancy !== 2'(exp_q.size()) || 32'(occupancy) > CAP) begin
        errors++;
        $display("FAIL stream_occ: got %0d want %0d (cap %0d) cycle %0d", occupancy, exp_q.size(), CAP, cyc);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: got %h want no entry", out_data);
        end else begin
          if (out_data !== exp_q[0]) begin
            errors++;
            $display("FAIL stream_data: got %h want %h index %0d", out_data, exp_q[0], rcvd);
          end
          void'(exp_q.pop_front());
        end
        rcvd++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (rcvd != 100) begin errors++; $display("FAIL stream_count: got %0d want 100", rcvd); end
  endtask

  task automatic test_nfields4();
    out_ready4 = 1'b0;
    in_valid4  = 1'b1;
    in_data4   = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    tick();
    in_valid4 = 1'b0;
    #1;
    checks++; if (occupancy4 !== 2'd1) begin errors++; $display("FAIL nf4_occ: got %0d want 1", occupancy4); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_data4[k] !== 16'(16'hA000 + k)) begin
        errors++;
        $display("FAIL nf4_field%0d: got %h want %h", k, out_data4[k], 16'(16'hA000 + k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skid();
    test_flush();
    test_reset_stall();
    test_stream();
    test_nfields4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
